// File: rtl/pulse_interpreter_pkg.sv
// Shared event codes and FSM state encoding for the Morse pulse interpreter.
package pulse_interpreter_pkg;

  localparam logic [2:0] EV_NONE         = 3'd0;
  localparam logic [2:0] EV_DIT          = 3'd1;
  localparam logic [2:0] EV_DASH         = 3'd2;
  localparam logic [2:0] EV_LETTER_SPACE = 3'd3;
  localparam logic [2:0] EV_WORD_SPACE   = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StMark,
    StGap
  } state_e;

endpackage

// File: rtl/pulse_interpreter_debouncer.sv
// Two-flop synchronizer followed by a stable-level filter: the output follows
// the synchronized input only after DEBOUNCE_WIDTH consecutive differing samples.
module debouncer #(
  parameter int unsigned DEBOUNCE_WIDTH = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_WIDTH + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEBOUNCE_WIDTH - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/pulse_interpreter.sv
// Classifies debounced key marks as DIT/DASH and low gaps as letter/word spaces,
// emitting one-cycle registered event codes.
module pulse_interpreter
  import pulse_interpreter_pkg::*;
#(
  parameter int unsigned DASH_TIME               = 200,
  parameter int unsigned INTER_LETTER_SPACE_TIME = 400,
  parameter int unsigned INTER_WORD_SPACE_TIME   = 1000,
  parameter int unsigned DEBOUNCE_WIDTH          = 10
) (
  input  logic       clock_1khz,
  input  logic       rst,
  input  logic       morse_in,
  output logic [2:0] pulse_event
);

  localparam int unsigned MW = $clog2(DASH_TIME + 1);
  localparam int unsigned GW = $clog2(INTER_WORD_SPACE_TIME + 1);

  logic          w_level;
  logic          r_level_d;
  logic          w_rise;
  logic          w_fall;
  state_e        r_state;
  state_e        w_state_next;
  logic [MW-1:0] r_mark_cnt;
  logic [MW-1:0] w_mark_next;
  logic [GW-1:0] r_gap_cnt;
  logic [GW-1:0] w_gap_next;
  logic [GW-1:0] w_gap_inc;
  logic [2:0]    r_event;
  logic [2:0]    w_event_next;

  debouncer #(
    .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)
  ) u_debouncer (
    .i_clk  (clock_1khz),
    .i_rst  (rst),
    .i_raw  (morse_in),
    .o_level(w_level)
  );

  assign w_rise    = w_level & ~r_level_d;
  assign w_fall    = ~w_level & r_level_d;
  assign w_gap_inc = (r_gap_cnt == GW'(INTER_WORD_SPACE_TIME)) ? r_gap_cnt : r_gap_cnt + 1'b1;

  always_ff @(posedge clock_1khz) begin
    if (rst) begin
      r_level_d  <= 1'b0;
      r_state    <= StIdle;
      r_mark_cnt <= '0;
      r_gap_cnt  <= '0;
      r_event    <= EV_NONE;
    end else begin
      r_level_d  <= w_level;
      r_state    <= w_state_next;
      r_mark_cnt <= w_mark_next;
      r_gap_cnt  <= w_gap_next;
      r_event    <= w_event_next;
    end
  end

  // In MARK the level can only go low via a fall; in GAP it can only go high via a rise.
  always_comb begin
    w_state_next = r_state;
    w_mark_next  = r_mark_cnt;
    w_gap_next   = r_gap_cnt;
    w_event_next = EV_NONE;
    unique case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_state_next = StMark;
          w_mark_next  = MW'(1);
          w_gap_next   = '0;
        end
      end
      StMark: begin
        if (w_fall) begin
          w_state_next = StGap;
          w_gap_next   = GW'(1);
          w_event_next = (r_mark_cnt < MW'(DASH_TIME)) ? EV_DIT : EV_DASH;
        end else if (r_mark_cnt != MW'(DASH_TIME)) begin
          w_mark_next = r_mark_cnt + 1'b1;
        end
      end
      StGap: begin
        if (w_rise) begin
          w_state_next = StMark;
          w_mark_next  = MW'(1);
          w_gap_next   = '0;
        end else begin
          w_gap_next = w_gap_inc;
          if (w_gap_inc == GW'(INTER_WORD_SPACE_TIME)) begin
            w_event_next = EV_WORD_SPACE;
            w_state_next = StIdle;
          end else if (w_gap_inc == GW'(INTER_LETTER_SPACE_TIME)) begin
            w_event_next = EV_LETTER_SPACE;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign pulse_event = r_event;

endmodule

// File: tb/tb_pulse_interpreter.sv
// Bench for pulse_interpreter: instance 0 uses 2/5/16/1, instance 1 the defaults.
module tb_pulse_interpreter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_a = 1'b0;
  logic       m_b = 1'b0;
  logic [2:0] ev_a;
  logic [2:0] ev_b;

  always #5 clk = ~clk;

  pulse_interpreter #(
    .DASH_TIME              (2),
    .INTER_LETTER_SPACE_TIME(5),
    .INTER_WORD_SPACE_TIME  (16),
    .DEBOUNCE_WIDTH         (1)
  ) dut_a (
    .clock_1khz (clk),
    .rst        (rst),
    .morse_in   (m_a),
    .pulse_event(ev_a)
  );

  pulse_interpreter dut_b (
    .clock_1khz (clk),
    .rst        (rst),
    .morse_in   (m_b),
    .pulse_event(ev_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state: raw samples delayed by two, a window of recent samples,
  // current high/low run lengths and whether a mark is pending since reset/word.
  logic        s1[2];
  logic        s2[2];
  logic [15:0] win[2];
  logic        lvl[2];
  logic        prevl[2];
  int          hi[2];
  int          lo[2];
  bit          armed[2];
  logic [2:0]  exp_ev[2];

  int ev_cnt[2][8];
  int ev_cyc[2][8];

  function automatic int p_dash(input int i); return (i == 0) ? 2 : 200; endfunction
  function automatic int p_ils(input int i); return (i == 0) ? 5 : 400; endfunction
  function automatic int p_iws(input int i); return (i == 0) ? 16 : 1000; endfunction
  function automatic int p_db(input int i); return (i == 0) ? 1 : 10; endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic model_step(input int i, input logic r, input logic m);
    logic [15:0] mask;
    logic        cur;
    if (r) begin
      s1[i] = 1'b0; s2[i] = 1'b0; win[i] = '0; lvl[i] = 1'b0; prevl[i] = 1'b0;
      hi[i] = 0; lo[i] = 0; armed[i] = 1'b0; exp_ev[i] = 3'd0;
    end else begin
      exp_ev[i] = 3'd0;
      cur = lvl[i];
      if (cur) begin
        if (!prevl[i]) begin
          hi[i] = 1;
          armed[i] = 1'b1;
        end else begin
          hi[i]++;
        end
      end else if (prevl[i]) begin
        exp_ev[i] = (hi[i] >= p_dash(i)) ? 3'd2 : 3'd1;
        lo[i] = 1;
      end else if (armed[i]) begin
        lo[i]++;
        if (lo[i] == p_iws(i)) begin
          exp_ev[i] = 3'd4;
          armed[i] = 1'b0;
        end else if (lo[i] == p_ils(i)) begin
          exp_ev[i] = 3'd3;
        end
      end
      prevl[i] = cur;
      win[i] = {win[i][14:0], s2[i]};
      mask = 16'((32'd1 << p_db(i)) - 1);
      if (((win[i] ^ {16{lvl[i]}}) & mask) == mask) lvl[i] = ~lvl[i];
      s2[i] = s1[i];
      s1[i] = m;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0, rst, m_a);
    model_step(1, rst, m_b);
  end

  always @(negedge clk) begin
    check("ev_a_vs_model", int'(ev_a), int'(exp_ev[0]));
    check("ev_b_vs_model", int'(ev_b), int'(exp_ev[1]));
    if (ev_a != 3'd0) begin ev_cnt[0][ev_a]++; ev_cyc[0][ev_a] = cyc; end
    if (ev_b != 3'd0) begin ev_cnt[1][ev_b]++; ev_cyc[1][ev_b] = cyc; end
  end

  task automatic clear_log();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 8; j++) begin
        ev_cnt[i][j] = 0;
        ev_cyc[i][j] = 0;
      end
    end
  endtask

  task automatic set_in(input int i, input logic v);
    if (i == 0) m_a = v; else m_b = v;
  endtask

  task automatic pulse(input int i, input int n, output int t0);
    @(negedge clk);
    t0 = cyc + 1;
    set_in(i, 1'b1);
    repeat (n) @(negedge clk);
    set_in(i, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int total(input int i);
    return ev_cnt[i][1] + ev_cnt[i][2] + ev_cnt[i][3] + ev_cnt[i][4];
  endfunction

  initial begin
    int t0;
    int t2;
    clear_log();
    rst = 1'b1;
    idle(3);
    check("reset_ev_a", int'(ev_a), 0);
    check("reset_ev_b", int'(ev_b), 0);
    rst = 1'b0;
    idle(5);

    // One-cycle mark on the small instance: DIT, then letter and word spaces.
    clear_log();
    pulse(0, 1, t0);
    idle(30);
    check("dit_count", ev_cnt[0][1], 1);
    check("dit_time", ev_cyc[0][1] - t0, 4);
    check("letter_time", ev_cyc[0][3] - t0, 8);
    check("word_time", ev_cyc[0][4] - t0, 19);
    check("dit_total", total(0), 3);

    clear_log();
    pulse(0, 5, t0);
    idle(30);
    check("dash5_count", ev_cnt[0][2], 1);
    check("dash5_dit", ev_cnt[0][1], 0);

    clear_log();
    pulse(0, 2, t0);
    idle(30);
    check("dash2_count", ev_cnt[0][2], 1);
    check("dash2_dit", ev_cnt[0][1], 0);

    // Eight-cycle gap between marks: a letter space but no word space.
    clear_log();
    pulse(0, 1, t0);
    idle(7);
    pulse(0, 1, t2);
    idle(30);
    check("gap8_dits", ev_cnt[0][1], 2);
    check("gap8_letters", ev_cnt[0][3], 2);
    check("gap8_words", ev_cnt[0][4], 1);
    check("gap8_word_after_2nd", int'(ev_cyc[0][4] > t2), 1);

    // Reset while a 3-cycle-old mark is in flight, then a long low.
    clear_log();
    @(negedge clk);
    m_a = 1'b1;
    idle(3);
    rst = 1'b1;
    m_a = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(100);
    check("rst_mid_mark_events", total(0), 0);

    // Key held through reset is seen as a new 3-cycle mark afterwards.
    clear_log();
    @(negedge clk);
    m_a = 1'b1;
    idle(5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    m_a = 1'b0;
    idle(40);
    check("held_dash", ev_cnt[0][2], 1);
    check("held_dit", ev_cnt[0][1], 0);
    check("held_word", ev_cnt[0][4], 1);

    // Default instance: a one-cycle glitch is filtered out.
    clear_log();
    pulse(1, 1, t0);
    idle(50);
    check("glitch_events", total(1), 0);

    // Default instance: 50 ms mark then 1.1 s low.
    clear_log();
    pulse(1, 50, t0);
    idle(1100);
    check("def_dit_count", ev_cnt[1][1], 1);
    check("def_dit_time", ev_cyc[1][1] - t0, 62);
    check("def_letter_time", ev_cyc[1][3] - t0, 461);
    check("def_word_time", ev_cyc[1][4] - t0, 1061);
    check("def_total", total(1), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_interpreter.md
PULSE_INTERPRETER -- requirements
Module: pulse_interpreter

Interface
REQ-001 Parameter DASH_TIME, default 200: minimum debounced high duration, in clock cycles, classified as a dash.
REQ-002 Parameter INTER_LETTER_SPACE_TIME, default 400: debounced low duration, in cycles, that signals an inter-letter space.
REQ-003 Parameter INTER_WORD_SPACE_TIME, default 1000: debounced low duration, in cycles, that signals an inter-word space; SHALL be greater than INTER_LETTER_SPACE_TIME.
REQ-004 Parameter DEBOUNCE_WIDTH, default 10: consecutive equal raw samples required before the debounced level changes; minimum 1.
REQ-005 clock_1khz  input  1  the single clock (1 kHz); all logic is on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 morse_in  input  1  raw, asynchronous key level (1 = key down).
REQ-008 pulse_event  output  3  registered event code: 0 NONE, 1 DIT, 2 DASH, 3 LETTER_SPACE, 4 WORD_SPACE; codes 5-7 are never driven.

Function
REQ-009 morse_in SHALL pass through a 2-flop synchronizer before debouncing.
REQ-010 The debounced level SHALL change only after the synchronized input has differed from it for DEBOUNCE_WIDTH consecutive cycles; shorter glitches SHALL be ignored.
REQ-011 The FSM SHALL have three states: IDLE (low, no pending mark), MARK (debounced high), and GAP (low after a mark).
REQ-012 IDLE→MARK on a debounced rising edge; the mark counter SHALL load 1.
REQ-013 In MARK, the counter SHALL increment each high cycle and saturate at DASH_TIME.
REQ-014 On a debounced falling edge in MARK, the FSM SHALL enter GAP and, on the next cycle, drive DIT if the count is less than DASH_TIME, else DASH.
REQ-015 In GAP, the low counter SHALL start at 1 on the first low cycle and increment each cycle, saturating at INTER_WORD_SPACE_TIME.
REQ-016 When the low count equals INTER_LETTER_SPACE_TIME, LETTER_SPACE SHALL be driven for one cycle.
REQ-017 When the low count equals INTER_WORD_SPACE_TIME, WORD_SPACE SHALL be driven for one cycle and the FSM SHALL return to IDLE.
REQ-018 A debounced rising edge in GAP SHALL go to MARK and clear the low counter; any pending space event is abandoned.
REQ-019 Every non-NONE event SHALL last exactly one cycle; pulse_event SHALL be NONE at all other times.
REQ-020 At most one event per cycle; no space events are emitted in IDLE, so there are none after reset or after a word space until a new mark occurs.
REQ-021 Counter widths SHALL be $clog2(max parameter + 1); counters SHALL never wrap.

Reset
REQ-022 While rst=1 at a clock edge: pulse_event=0, state=IDLE, debounced level=0, synchronizer=0, all counters=0.
REQ-023 Reset asserted mid-mark or mid-gap SHALL discard the partial measurement with no event emitted.
REQ-024 After reset, a key already held high SHALL be recognized as a new mark once debounced.

Structure
REQ-025 A shared package SHALL hold the event-code localparams (EV_NONE..EV_WORD_SPACE) and the FSM state encoding.
REQ-026 Debounce SHALL be a sub-module named debouncer (synchronizer, counter, stable-level output), parameterized by DEBOUNCE_WIDTH.
REQ-027 The top module SHALL contain the FSM, the mark and gap counters, and the output register.

Verification (params 2/5/16/1 unless stated)
REQ-028 High 1 cycle, then low → one DIT (1) pulse, LETTER_SPACE (3) after 5 low cycles, WORD_SPACE (4) after 16, then NONE.
REQ-029 High 5 cycles → one DASH (2); high exactly 2 cycles → DASH; high 1 cycle → DIT.
REQ-030 Defaults, 1-cycle high glitch on morse_in → pulse_event stays 0 throughout.
REQ-031 Mark, low 8 cycles, then mark → exactly one LETTER_SPACE, no WORD_SPACE between the marks.
REQ-032 rst pulsed during a 3-cycle-old high → no DIT/DASH; 100 cycles low after reset → no space events.
REQ-033 Defaults: high 50 ms, then low 1 s → DIT, LETTER_SPACE at 400 low cycles, WORD_SPACE at 1000 low cycles (plus debounce latency).
